instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Encoder counterpart of the control-unit opcode decoder: accepts instruction requests as decoded fields (class, rd, rs1, rs2, funct3, funct7, imm) and assembles legal RV32I 32-bit words.
- Words are buffered in a small FIFO and streamed with addresses to the instruction-memory write port.
- Used for program loading and for self-check benches that feed the single-cycle core.

Parameters:
- ADDR_W, 32, width of the output address counter.
- FIFO_DEPTH, 4, encoded-word buffer depth; power of 2, at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  one-cycle pulse; loads the address counter, flushes the FIFO, clears errors, enters LOAD.
- start_addr  input  ADDR_W  first write address, sampled on start.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- in_last  input  1  marks the final request of a program.
- in_class  input  3  0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6-7 illegal.
- in_rd, in_rs1, in_rs2  input  5 each  register fields.
- in_funct3  input  3  funct3 field.
- in_funct7  input  7  funct7 field.
- in_imm  input  32  byte-offset immediate, sign-extended.
- out_valid  output  1  encoded word available.
- out_ready  input  1  memory consumes the word when out_valid && out_ready.
- out_addr  output  ADDR_W  write address of the head word.
- out_data  output  32  head encoded word; 0 when out_valid=0.
- done  output  1  high in DONE state.
- err_illegal  output  1  sticky; set when an illegal class is accepted.
- err_range  output  1  sticky; only driven when IMM_CHECK_EN is defined, else tied 0.

Behaviour:
- Reset state: IDLE. in_ready=0, out_valid=0, out_data=0, out_addr=0, done=0, err_*=0, FIFO empty.
- FSM transitions:
  - IDLE --start--> LOAD.
  - LOAD --accept with in_last--> DRAIN.
  - DRAIN --FIFO empty--> DONE.
  - DONE --start--> LOAD.
  - start in any state (including mid-LOAD or mid-DRAIN) discards FIFO contents and goes to LOAD. start has priority over any same-cycle accept or pop.
- in_ready = (state==LOAD) && FIFO not full. There is no bypass when full.
- Accept of a legal class pushes the encoded word at that edge; out_valid rises the next cycle (latency 1 from acceptance to visibility).
- Accept of class 6/7 sets err_illegal and pushes nothing; in_last still takes effect.
- Pop on out_valid && out_ready: head advances and out_addr += 4, wrapping modulo 2^ADDR_W.
- Simultaneous push and pop are allowed when not full; occupancy is unchanged.
- Encoding (op = opcode):
  - R: f7|rs2|rs1|f3|rd|0110011.
  - I: imm[11:0]|rs1|f3|rd|0010011. When f3 is 001 or 101, bits[31:25] = funct7 and bits[24:20] = imm[4:0].
  - LOAD: imm[11:0]|rs1|f3|rd|0000011.
  - STORE: imm[11:5]|rs2|rs1|f3|imm[4:0]|0100011.
  - BRANCH: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|1100011.
  - JAL: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|1101111.
  - Fields not used by a class are ignored. Imm bits beyond the field are truncated.
- errors clear only on start or rst.

Optional Feature:
- Macro IMM_CHECK_EN.
- Defined: on accept, the immediate is range-checked per class:
  - I/LOAD/STORE: signed 12-bit.
  - I-shifts: 0..31.
  - BRANCH: signed 13-bit, bit0=0.
  - JAL: signed 21-bit, bit0=0.
  - A violation sets err_range and drops the word; no push, address unchanged.
- Undefined: no check, silent truncation, err_range=0.

Test Plan:
- Encodings, each at start_addr=0x100 after start, out_ready=1:
  - R add x3,x1,x2 -> 0x002081B3 @0x100.
  - addi x5,x0,-1 (imm 0xFFFFFFFF) -> 0xFFF00293 @0x104.
  - sw x2,8(x1) -> 0x0020A423 @0x108.
  - beq x0,x0,8 -> 0x00000463 @0x10C.
  - jal x1,16 with in_last -> 0x010000EF @0x110; done=1 the cycle after the FIFO empties.
- Backpressure: out_ready=0, in_valid held -> in_ready drops after 4 accepts. Release out_ready -> addresses 0x100, 0x104, 0x108, 0x10C in order, no loss or duplication.
- Illegal class 6 between two addi -> err_illegal=1, only 2 words emitted, at 0x100 and 0x104.
- start pulsed with 3 words queued, start_addr=0x200 -> out_valid=0 next cycle, err cleared, next word emitted @0x200.
- addi imm=2048: with IMM_CHECK_EN -> err_range=1, nothing emitted. Without it -> 0x80000013 emitted.
- rst asserted mid-DRAIN, asynchronously -> all outputs go to reset values immediately. in_ready stays 0 until start.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: assembles words from decoded fields, buffers them in a FIFO
// and streams {addr, word} to the instruction-memory write port. IMM_CHECK_EN enables immediate range checks.
module instr_encoder #(
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        in_class,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_data,
    output logic              done,
    output logic              err_illegal,
    output logic              err_range
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t            r_state, w_next;
    logic [31:0]       r_mem [FIFO_DEPTH];
    logic [PW:0]       r_wptr, r_rptr;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err_illegal;
    logic              w_empty, w_full, w_accept, w_legal, w_range_ok, w_push, w_pop;
    logic [31:0]       w_word;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign in_ready = (r_state == S_LOAD) && !w_full;
    assign w_accept = in_valid && in_ready;
    assign w_legal  = (in_class < 3'd6);
    assign w_push   = w_accept && w_legal && w_range_ok;
    assign w_pop    = !w_empty && out_ready;

    assign out_valid   = !w_empty;
    assign out_data    = out_valid ? r_mem[r_rptr[PW-1:0]] : 32'h0;
    assign out_addr    = r_addr;
    assign done        = (r_state == S_DONE);
    assign err_illegal = r_err_illegal;

    always_comb begin
        w_word = 32'h0;
        case (in_class)
            3'd0: w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            3'd1: begin
                if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
                    w_word = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
                else
                    w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
            end
            3'd2: w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
            3'd3: w_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
            3'd4: w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], 7'b1100011};
            3'd5: w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
            default: w_word = 32'h0;
        endcase
    end

`ifdef IMM_CHECK_EN
    logic r_err_range;

    always_comb begin
        w_range_ok = 1'b1;
        case (in_class)
            3'd1: begin
                if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
                    w_range_ok = ~|in_imm[31:5];
                else
                    w_range_ok = (&in_imm[31:11]) | (~|in_imm[31:11]);
            end
            3'd2, 3'd3: w_range_ok = (&in_imm[31:11]) | (~|in_imm[31:11]);
            3'd4: w_range_ok = ((&in_imm[31:12]) | (~|in_imm[31:12])) & ~in_imm[0];
            3'd5: w_range_ok = ((&in_imm[31:20]) | (~|in_imm[31:20])) & ~in_imm[0];
            default: w_range_ok = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_err_range <= 1'b0;
        else if (start)
            r_err_range <= 1'b0;
        else if (w_accept && w_legal && !w_range_ok)
            r_err_range <= 1'b1;
    end

    assign err_range = r_err_range;
`else
    logic w_unused_imm;
    assign w_unused_imm = &{1'b0, in_imm[31:21]};
    assign w_range_ok   = 1'b1;
    assign err_range    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (w_push && !start)
            r_mem[r_wptr[PW-1:0]] <= w_word;
    end

    // start wins over any same-cycle push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_addr        <= '0;
            r_err_illegal <= 1'b0;
        end else if (start) begin
            r_state       <= w_next;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_addr        <= start_addr;
            r_err_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
                r_addr <= r_addr + ADDR_W'(4);
            end
            if (w_accept && !w_legal)
                r_err_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        if (start)
            w_next = S_LOAD;
        else begin
            case (r_state)
                S_LOAD:  if (w_accept && in_last) w_next = S_DRAIN;
                S_DRAIN: if (w_empty) w_next = S_DONE;
                default: w_next = r_state;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a {addr, word} scoreboard checked on every pop.
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_last, out_ready;
    logic [31:0] start_addr, in_imm;
    logic [2:0]  in_class, in_funct3;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [6:0]  in_funct7;
    logic        in_ready, out_valid, done, err_illegal, err_range;
    logic [31:0] out_addr, out_data;

    int          errors = 0;
    int          checks = 0;
    int          n_pop  = 0;
    logic [63:0] q[$];
    logic [31:0] exp_addr, exp_word;
    logic        exp_push;
    logic        acc;

    instr_encoder #(.ADDR_W(32), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .done(done), .err_illegal(err_illegal), .err_range(err_range)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %08h want %08h", tag, obs, expv);
        end
    endtask

    // One clock: sample at negedge (scoreboard push/pop), then return #1 after posedge.
    task automatic cyc(output logic accepted);
        logic [63:0] e;
        @(negedge clk);
        accepted = in_valid && in_ready;
        if (accepted && exp_push) begin
            q.push_back({exp_addr, exp_word});
            exp_addr = exp_addr + 32'd4;
        end
        if (out_valid && out_ready) begin
            n_pop++;
            if (q.size() == 0) begin
                chk("unexpected_word", out_data, 32'hxxxxxxxx);
            end else begin
                e = q.pop_front();
                chk("out_addr", out_addr, e[63:32]);
                chk("out_data", out_data, e[31:0]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        logic a;
        cyc(a);
    endtask

    task automatic send(input logic [2:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input logic last, input logic [31:0] w,
                        input logic push);
        in_class = cls; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
        exp_word = w; exp_push = push; in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cyc(acc);
            if (acc) break;
        end
        if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
        in_valid = 1'b0; in_last = 1'b0; exp_push = 1'b0;
    endtask

    task automatic addi(input logic [4:0] rd, input logic [31:0] imm, input logic last);
        send(3'd1, rd, 5'd0, 5'd0, 3'd0, 7'd0, imm, last,
             {imm[11:0], 5'd0, 3'd0, rd, 7'b0010011}, 1'b1);
    endtask

    task automatic do_start(input logic [31:0] a);
        start = 1'b1; start_addr = a;
        tick();
        start = 1'b0;
        q.delete();
        exp_addr = a;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 50; i++) begin
            if (done) break;
            tick();
        end
        chk("done", 32'(done), 32'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_addr = '0; in_valid = 1'b0; in_last = 1'b0;
        in_class = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0;
        in_funct7 = '0; in_imm = '0; out_ready = 1'b0; exp_addr = '0; exp_word = '0;
        exp_push = 1'b0;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_addr", out_addr, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_errs", {30'd0, err_illegal, err_range}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("idle_in_ready", 32'(in_ready), 32'd0);

        // Encodings, one of each class
        out_ready = 1'b1;
        do_start(32'h100);
        chk("load_in_ready", 32'(in_ready), 32'd1);
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0, 32'h002081B3, 1'b1);
        addi(5'd5, 32'hFFFFFFFF, 1'b0);
        send(3'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0, 32'h0020A423, 1'b1);
        send(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b0, 32'h00000463, 1'b1);
        send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16, 1'b1, 32'h010000EF, 1'b1);
        chk("jal_visible", 32'(out_valid), 32'd1);
        tick();
        chk("drained", 32'(out_valid), 32'd0);
        chk("done_not_yet", 32'(done), 32'd0);
        tick();
        chk("done_after_empty", 32'(done), 32'd1);
        chk("sb_empty_1", q.size(), 32'd0);

        // Shift-immediate form and a LOAD
        do_start(32'h180);
        send(3'd1, 5'd4, 5'd6, 5'd0, 3'b101, 7'h20, 32'd3, 1'b0, 32'h40335213, 1'b1);
        send(3'd2, 5'd7, 5'd2, 5'd0, 3'd2, 7'd0, 32'hFFFFFFFC, 1'b1, 32'hFFC12383, 1'b1);
        wait_done();

        // Backpressure: FIFO fills at 4 then drains in order
        out_ready = 1'b0;
        do_start(32'h100);
        for (int i = 1; i <= 4; i++) addi(5'(i), 32'(i), 1'b0);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1; in_class = 3'd1; in_rd = 5'd5; in_imm = 32'd5;
        tick(); tick();
        chk("full_hold", 32'(in_ready), 32'd0);
        chk("full_head_addr", out_addr, 32'h100);
        in_valid = 1'b0;
        out_ready = 1'b1;
        addi(5'd5, 32'd5, 1'b1);
        wait_done();
        chk("sb_empty_2", q.size(), 32'd0);

        // Illegal class between two addi
        do_start(32'h100);
        n_pop = 0;
        addi(5'd1, 32'd1, 1'b0);
        send(3'd6, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 1'b0, 32'd0, 1'b0);
        addi(5'd2, 32'd2, 1'b1);
        wait_done();
        chk("err_illegal", 32'(err_illegal), 32'd1);
        chk("illegal_pops", 32'(n_pop), 32'd2);

        // start flush with 3 words queued
        out_ready = 1'b0;
        do_start(32'h300);
        send(3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, 32'd0, 1'b0);
        for (int i = 1; i <= 3; i++) addi(5'(i), 32'(i), 1'b0);
        chk("pre_flush_err", 32'(err_illegal), 32'd1);
        chk("pre_flush_valid", 32'(out_valid), 32'd1);
        do_start(32'h200);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_err", 32'(err_illegal), 32'd0);
        chk("flush_addr", out_addr, 32'h200);
        out_ready = 1'b1;
        n_pop = 0;
        addi(5'd7, 32'd7, 1'b1);
        wait_done();
        chk("flush_pops", 32'(n_pop), 32'd1);

        // Out-of-range addi immediate
        do_start(32'h100);
        n_pop = 0;
`ifdef IMM_CHECK_EN
        send(3'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b1, 32'h80000013, 1'b0);
        wait_done();
        chk("err_range", 32'(err_range), 32'd1);
        chk("range_pops", 32'(n_pop), 32'd0);
`else
        send(3'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b1, 32'h80000013, 1'b1);
        wait_done();
        chk("err_range_tied", 32'(err_range), 32'd0);
        chk("range_pops", 32'(n_pop), 32'd1);
`endif

        // Asynchronous reset mid-DRAIN
        out_ready = 1'b0;
        do_start(32'h100);
        addi(5'd1, 32'd1, 1'b0);
        addi(5'd2, 32'd2, 1'b1);
        chk("drain_valid", 32'(out_valid), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", out_data, 32'd0);
        chk("arst_out_addr", out_addr, 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        tick(); tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd0);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        chk("sb_final", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
